// File: rtl/axil_arb_pkg.sv
// Shared types for the two-master AXI4-Lite arbiter.
// State encodings, grant index and master count.
package axil_arb_pkg;

  localparam int NUM_MASTERS = 2;

  typedef enum logic [1:0] {
    W_IDLE,
    W_FWD,
    W_RESP
  } wr_state_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_FWD,
    R_DATA
  } rd_state_t;

  typedef logic grant_t;

endpackage

// File: rtl/axil_rr_picker.sv
// Two-request round-robin picker with a priority pointer.
// AXIL_ARB_FIXED_PRIO_EN: master 0 always wins, no pointer.
module axil_rr_picker
  import axil_arb_pkg::*;
(
  input  logic                   aclk,
  input  logic                   areset,
  input  logic [NUM_MASTERS-1:0] req,
  input  logic                   upd,
  input  grant_t                 upd_grant,
  output grant_t                 grant
);

`ifdef AXIL_ARB_FIXED_PRIO_EN
  logic unused_ok;
  assign unused_ok = ^{aclk, areset, upd, upd_grant};
  assign grant = grant_t'(~req[0]);
`else
  grant_t ptr;

  // Pointer moves to the master that did not just finish
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      ptr <= '0;
    end else if (upd) begin
      ptr <= ~upd_grant;
    end
  end

  assign grant = (&req) ? ptr : grant_t'(~req[0]);
`endif

endmodule

// File: rtl/axil_arbiter_2x1.sv
// Two-master to one-slave AXI4-Lite arbiter, independent read/write.
// Define AXIL_ARB_FIXED_PRIO_EN for fixed master-0 priority.
module axil_arbiter_2x1
  import axil_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [ADDR_WIDTH-1:0] s0_axil_awaddr,
  input  logic [2:0]            s0_axil_awprot,
  input  logic                  s0_axil_awvalid,
  output logic                  s0_axil_awready,
  input  logic [DATA_WIDTH-1:0] s0_axil_wdata,
  input  logic [STRB_WIDTH-1:0] s0_axil_wstrb,
  input  logic                  s0_axil_wvalid,
  output logic                  s0_axil_wready,
  output logic                  s0_axil_bvalid,
  input  logic                  s0_axil_bready,
  input  logic [ADDR_WIDTH-1:0] s0_axil_araddr,
  input  logic [2:0]            s0_axil_arprot,
  input  logic                  s0_axil_arvalid,
  output logic                  s0_axil_arready,
  output logic [DATA_WIDTH-1:0] s0_axil_rdata,
  output logic [1:0]            s0_axil_rresp,
  output logic                  s0_axil_rvalid,
  input  logic                  s0_axil_rready,
  input  logic [ADDR_WIDTH-1:0] s1_axil_awaddr,
  input  logic [2:0]            s1_axil_awprot,
  input  logic                  s1_axil_awvalid,
  output logic                  s1_axil_awready,
  input  logic [DATA_WIDTH-1:0] s1_axil_wdata,
  input  logic [STRB_WIDTH-1:0] s1_axil_wstrb,
  input  logic                  s1_axil_wvalid,
  output logic                  s1_axil_wready,
  output logic                  s1_axil_bvalid,
  input  logic                  s1_axil_bready,
  input  logic [ADDR_WIDTH-1:0] s1_axil_araddr,
  input  logic [2:0]            s1_axil_arprot,
  input  logic                  s1_axil_arvalid,
  output logic                  s1_axil_arready,
  output logic [DATA_WIDTH-1:0] s1_axil_rdata,
  output logic [1:0]            s1_axil_rresp,
  output logic                  s1_axil_rvalid,
  input  logic                  s1_axil_rready,
  output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
  output logic [2:0]            m_axil_awprot,
  output logic                  m_axil_awvalid,
  input  logic                  m_axil_awready,
  output logic [DATA_WIDTH-1:0] m_axil_wdata,
  output logic [STRB_WIDTH-1:0] m_axil_wstrb,
  output logic                  m_axil_wvalid,
  input  logic                  m_axil_wready,
  input  logic                  m_axil_bvalid,
  output logic                  m_axil_bready,
  output logic [ADDR_WIDTH-1:0] m_axil_araddr,
  output logic [2:0]            m_axil_arprot,
  output logic                  m_axil_arvalid,
  input  logic                  m_axil_arready,
  input  logic [DATA_WIDTH-1:0] m_axil_rdata,
  input  logic [1:0]            m_axil_rresp,
  input  logic                  m_axil_rvalid,
  output logic                  m_axil_rready
);

  wr_state_t w_st, w_nxt;
  rd_state_t r_st, r_nxt;
  grant_t    wg, wg_nxt, wpick;
  grant_t    rg, rg_nxt, rpick;
  logic      aw_done, aw_dn_nxt;
  logic      w_done, w_dn_nxt;
  logic      aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic      w_upd, r_upd;

  axil_rr_picker u_wpick (
    .aclk      (aclk),
    .areset    (areset),
    .req       ({s1_axil_awvalid, s0_axil_awvalid}),
    .upd       (w_upd),
    .upd_grant (wg),
    .grant     (wpick)
  );

  axil_rr_picker u_rpick (
    .aclk      (aclk),
    .areset    (areset),
    .req       ({s1_axil_arvalid, s0_axil_arvalid}),
    .upd       (r_upd),
    .upd_grant (rg),
    .grant     (rpick)
  );

  assign aw_hs = m_axil_awvalid & m_axil_awready;
  assign w_hs  = m_axil_wvalid & m_axil_wready;
  assign b_hs  = m_axil_bvalid & m_axil_bready;
  assign ar_hs = m_axil_arvalid & m_axil_arready;
  assign r_hs  = m_axil_rvalid & m_axil_rready;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      w_st    <= W_IDLE;
      wg      <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      r_st    <= R_IDLE;
      rg      <= '0;
    end else begin
      w_st    <= w_nxt;
      wg      <= wg_nxt;
      aw_done <= aw_dn_nxt;
      w_done  <= w_dn_nxt;
      r_st    <= r_nxt;
      rg      <= rg_nxt;
    end
  end

  // AW and W may complete in either order, or together
  always_comb begin
    w_nxt     = w_st;
    wg_nxt    = wg;
    aw_dn_nxt = aw_done;
    w_dn_nxt  = w_done;
    w_upd     = 1'b0;
    unique case (w_st)
      W_IDLE: begin
        if (s0_axil_awvalid | s1_axil_awvalid) begin
          w_nxt     = W_FWD;
          wg_nxt    = wpick;
          aw_dn_nxt = 1'b0;
          w_dn_nxt  = 1'b0;
        end
      end
      W_FWD: begin
        aw_dn_nxt = aw_done | aw_hs;
        w_dn_nxt  = w_done | w_hs;
        if (aw_dn_nxt & w_dn_nxt) begin
          w_nxt = W_RESP;
        end
      end
      W_RESP: begin
        if (b_hs) begin
          w_nxt = W_IDLE;
          w_upd = 1'b1;
        end
      end
      default: w_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    m_axil_awaddr   = '0;
    m_axil_awprot   = '0;
    m_axil_awvalid  = 1'b0;
    m_axil_wdata    = '0;
    m_axil_wstrb    = '0;
    m_axil_wvalid   = 1'b0;
    m_axil_bready   = 1'b0;
    s0_axil_awready = 1'b0;
    s1_axil_awready = 1'b0;
    s0_axil_wready  = 1'b0;
    s1_axil_wready  = 1'b0;
    s0_axil_bvalid  = 1'b0;
    s1_axil_bvalid  = 1'b0;
    unique case (w_st)
      W_FWD: begin
        m_axil_awaddr   = wg ? s1_axil_awaddr : s0_axil_awaddr;
        m_axil_awprot   = wg ? s1_axil_awprot : s0_axil_awprot;
        m_axil_awvalid  = ~aw_done &
                          (wg ? s1_axil_awvalid : s0_axil_awvalid);
        m_axil_wdata    = wg ? s1_axil_wdata : s0_axil_wdata;
        m_axil_wstrb    = wg ? s1_axil_wstrb : s0_axil_wstrb;
        m_axil_wvalid   = ~w_done &
                          (wg ? s1_axil_wvalid : s0_axil_wvalid);
        s0_axil_awready = ~wg & ~aw_done & m_axil_awready;
        s1_axil_awready = wg & ~aw_done & m_axil_awready;
        s0_axil_wready  = ~wg & ~w_done & m_axil_wready;
        s1_axil_wready  = wg & ~w_done & m_axil_wready;
      end
      W_RESP: begin
        m_axil_bready  = wg ? s1_axil_bready : s0_axil_bready;
        s0_axil_bvalid = ~wg & m_axil_bvalid;
        s1_axil_bvalid = wg & m_axil_bvalid;
      end
      default: ;
    endcase
  end

  always_comb begin
    r_nxt  = r_st;
    rg_nxt = rg;
    r_upd  = 1'b0;
    unique case (r_st)
      R_IDLE: begin
        if (s0_axil_arvalid | s1_axil_arvalid) begin
          r_nxt  = R_FWD;
          rg_nxt = rpick;
        end
      end
      R_FWD: begin
        if (ar_hs) begin
          r_nxt = R_DATA;
        end
      end
      R_DATA: begin
        if (r_hs) begin
          r_nxt = R_IDLE;
          r_upd = 1'b1;
        end
      end
      default: r_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    m_axil_araddr   = '0;
    m_axil_arprot   = '0;
    m_axil_arvalid  = 1'b0;
    m_axil_rready   = 1'b0;
    s0_axil_arready = 1'b0;
    s1_axil_arready = 1'b0;
    s0_axil_rdata   = '0;
    s1_axil_rdata   = '0;
    s0_axil_rresp   = '0;
    s1_axil_rresp   = '0;
    s0_axil_rvalid  = 1'b0;
    s1_axil_rvalid  = 1'b0;
    unique case (r_st)
      R_FWD: begin
        m_axil_araddr   = rg ? s1_axil_araddr : s0_axil_araddr;
        m_axil_arprot   = rg ? s1_axil_arprot : s0_axil_arprot;
        m_axil_arvalid  = rg ? s1_axil_arvalid : s0_axil_arvalid;
        s0_axil_arready = ~rg & m_axil_arready;
        s1_axil_arready = rg & m_axil_arready;
      end
      R_DATA: begin
        m_axil_rready = rg ? s1_axil_rready : s0_axil_rready;
        if (rg) begin
          s1_axil_rdata  = m_axil_rdata;
          s1_axil_rresp  = m_axil_rresp;
          s1_axil_rvalid = m_axil_rvalid;
        end else begin
          s0_axil_rdata  = m_axil_rdata;
          s0_axil_rresp  = m_axil_rresp;
          s0_axil_rvalid = m_axil_rvalid;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_axil_arbiter_2x1.sv
// Scoreboard bench for axil_arbiter_2x1 with a small slave memory model.
// Expected order follows AXIL_ARB_FIXED_PRIO_EN when defined.
module tb_axil_arbiter_2x1;

  localparam int TMO = 50;

  logic        aclk = 1'b0;
  logic        areset;
  logic [31:0] s0_axil_awaddr, s1_axil_awaddr;
  logic [2:0]  s0_axil_awprot, s1_axil_awprot;
  logic        s0_axil_awvalid, s1_axil_awvalid;
  logic        s0_axil_awready, s1_axil_awready;
  logic [31:0] s0_axil_wdata, s1_axil_wdata;
  logic [3:0]  s0_axil_wstrb, s1_axil_wstrb;
  logic        s0_axil_wvalid, s1_axil_wvalid;
  logic        s0_axil_wready, s1_axil_wready;
  logic        s0_axil_bvalid, s1_axil_bvalid;
  logic        s0_axil_bready, s1_axil_bready;
  logic [31:0] s0_axil_araddr, s1_axil_araddr;
  logic [2:0]  s0_axil_arprot, s1_axil_arprot;
  logic        s0_axil_arvalid, s1_axil_arvalid;
  logic        s0_axil_arready, s1_axil_arready;
  logic [31:0] s0_axil_rdata, s1_axil_rdata;
  logic [1:0]  s0_axil_rresp, s1_axil_rresp;
  logic        s0_axil_rvalid, s1_axil_rvalid;
  logic        s0_axil_rready, s1_axil_rready;
  logic [31:0] m_axil_awaddr, m_axil_wdata, m_axil_araddr, m_axil_rdata;
  logic [2:0]  m_axil_awprot, m_axil_arprot;
  logic [3:0]  m_axil_wstrb;
  logic [1:0]  m_axil_rresp;
  logic        m_axil_awvalid, m_axil_awready, m_axil_wvalid;
  logic        m_axil_wready, m_axil_bvalid, m_axil_bready;
  logic        m_axil_arvalid, m_axil_arready, m_axil_rvalid;
  logic        m_axil_rready;

  always #5 aclk = ~aclk;

  axil_arbiter_2x1 dut (
    .aclk            (aclk),
    .areset          (areset),
    .s0_axil_awaddr  (s0_axil_awaddr),
    .s0_axil_awprot  (s0_axil_awprot),
    .s0_axil_awvalid (s0_axil_awvalid),
    .s0_axil_awready (s0_axil_awready),
    .s0_axil_wdata   (s0_axil_wdata),
    .s0_axil_wstrb   (s0_axil_wstrb),
    .s0_axil_wvalid  (s0_axil_wvalid),
    .s0_axil_wready  (s0_axil_wready),
    .s0_axil_bvalid  (s0_axil_bvalid),
    .s0_axil_bready  (s0_axil_bready),
    .s0_axil_araddr  (s0_axil_araddr),
    .s0_axil_arprot  (s0_axil_arprot),
    .s0_axil_arvalid (s0_axil_arvalid),
    .s0_axil_arready (s0_axil_arready),
    .s0_axil_rdata   (s0_axil_rdata),
    .s0_axil_rresp   (s0_axil_rresp),
    .s0_axil_rvalid  (s0_axil_rvalid),
    .s0_axil_rready  (s0_axil_rready),
    .s1_axil_awaddr  (s1_axil_awaddr),
    .s1_axil_awprot  (s1_axil_awprot),
    .s1_axil_awvalid (s1_axil_awvalid),
    .s1_axil_awready (s1_axil_awready),
    .s1_axil_wdata   (s1_axil_wdata),
    .s1_axil_wstrb   (s1_axil_wstrb),
    .s1_axil_wvalid  (s1_axil_wvalid),
    .s1_axil_wready  (s1_axil_wready),
    .s1_axil_bvalid  (s1_axil_bvalid),
    .s1_axil_bready  (s1_axil_bready),
    .s1_axil_araddr  (s1_axil_araddr),
    .s1_axil_arprot  (s1_axil_arprot),
    .s1_axil_arvalid (s1_axil_arvalid),
    .s1_axil_arready (s1_axil_arready),
    .s1_axil_rdata   (s1_axil_rdata),
    .s1_axil_rresp   (s1_axil_rresp),
    .s1_axil_rvalid  (s1_axil_rvalid),
    .s1_axil_rready  (s1_axil_rready),
    .m_axil_awaddr   (m_axil_awaddr),
    .m_axil_awprot   (m_axil_awprot),
    .m_axil_awvalid  (m_axil_awvalid),
    .m_axil_awready  (m_axil_awready),
    .m_axil_wdata    (m_axil_wdata),
    .m_axil_wstrb    (m_axil_wstrb),
    .m_axil_wvalid   (m_axil_wvalid),
    .m_axil_wready   (m_axil_wready),
    .m_axil_bvalid   (m_axil_bvalid),
    .m_axil_bready   (m_axil_bready),
    .m_axil_araddr   (m_axil_araddr),
    .m_axil_arprot   (m_axil_arprot),
    .m_axil_arvalid  (m_axil_arvalid),
    .m_axil_arready  (m_axil_arready),
    .m_axil_rdata    (m_axil_rdata),
    .m_axil_rresp    (m_axil_rresp),
    .m_axil_rvalid   (m_axil_rvalid),
    .m_axil_rready   (m_axil_rready)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [31:0] exp_mar[$];
  logic [31:0] exp_maw[$];
  logic [35:0] exp_mw[$];
  logic [31:0] exp_r0[$];
  logic [31:0] exp_r1[$];
  int          exp_b0 = 0;
  int          exp_b1 = 0;

  logic [31:0] mem [logic [31:0]];
  logic        sl_rdy = 1'b1;
  int          bdelay = 0;

  task automatic check(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic unexp(input string nm);
    checks++;
    errors++;
    $display("FAIL %s unexpected handshake", nm);
  endtask

  task automatic tmo(input string nm);
    checks++;
    errors++;
    $display("FAIL %s timeout", nm);
  endtask

  function automatic logic any_out();
    return |{s0_axil_awready, s0_axil_wready, s0_axil_bvalid,
             s0_axil_arready, s0_axil_rdata, s0_axil_rresp,
             s0_axil_rvalid, s1_axil_awready, s1_axil_wready,
             s1_axil_bvalid, s1_axil_arready, s1_axil_rdata,
             s1_axil_rresp, s1_axil_rvalid, m_axil_awaddr,
             m_axil_awprot, m_axil_awvalid, m_axil_wdata,
             m_axil_wstrb, m_axil_wvalid, m_axil_bready,
             m_axil_araddr, m_axil_arprot, m_axil_arvalid,
             m_axil_rready};
  endfunction

  function automatic int pending();
    return exp_mar.size() + exp_maw.size() + exp_mw.size() +
           exp_r0.size() + exp_r1.size() + exp_b0 + exp_b1;
  endfunction

  initial forever begin
    @(posedge aclk);
    cyc++;
  end

  // Monitor: pops expectations whenever a handshake is about to occur
  initial forever begin
    @(negedge aclk);
    if (!areset) begin
      if (m_axil_arvalid && m_axil_arready) begin
        if (exp_mar.size() == 0) unexp("m_ar");
        else check("m_araddr", m_axil_araddr, exp_mar.pop_front());
      end
      if (m_axil_awvalid && m_axil_awready) begin
        if (exp_maw.size() == 0) unexp("m_aw");
        else check("m_awaddr", m_axil_awaddr, exp_maw.pop_front());
      end
      if (m_axil_wvalid && m_axil_wready) begin
        if (exp_mw.size() == 0) unexp("m_w");
        else check("m_wstrb_wdata", {m_axil_wstrb, m_axil_wdata},
                   exp_mw.pop_front());
      end
      if (s0_axil_rvalid && s0_axil_rready) begin
        if (exp_r0.size() == 0) unexp("s0_r");
        else check("s0_rdata", s0_axil_rdata, exp_r0.pop_front());
        check("s1_rdata_idle", s1_axil_rdata, 0);
      end
      if (s1_axil_rvalid && s1_axil_rready) begin
        if (exp_r1.size() == 0) unexp("s1_r");
        else check("s1_rdata", s1_axil_rdata, exp_r1.pop_front());
        check("s0_rdata_idle", s0_axil_rdata, 0);
      end
      if (s0_axil_bvalid && s0_axil_bready) begin
        if (exp_b0 == 0) unexp("s0_b");
        else begin
          exp_b0--;
          check("s1_bvalid_idle", s1_axil_bvalid, 0);
        end
      end
      if (s1_axil_bvalid && s1_axil_bready) begin
        if (exp_b1 == 0) unexp("s1_b");
        else begin
          exp_b1--;
          check("s0_bvalid_idle", s0_axil_bvalid, 0);
        end
      end
    end
  end

  // Slave memory model; B can be held off by bdelay cycles
  initial begin
    logic        ar_hs, r_hs, aw_hs, w_hs, b_hs;
    logic        have_aw, have_w, b_pend;
    logic [31:0] ara, awa, wd, cur;
    logic [3:0]  ws;
    int          bcnt;
    have_aw = 0; have_w = 0; b_pend = 0; bcnt = 0;
    ara = 0; awa = 0; wd = 0; ws = 0;
    m_axil_awready = 0; m_axil_wready = 0; m_axil_arready = 0;
    m_axil_bvalid = 0; m_axil_rvalid = 0;
    m_axil_rdata = 0; m_axil_rresp = 0;
    forever begin
      @(negedge aclk);
      ar_hs = m_axil_arvalid && m_axil_arready;
      r_hs  = m_axil_rvalid && m_axil_rready;
      aw_hs = m_axil_awvalid && m_axil_awready;
      w_hs  = m_axil_wvalid && m_axil_wready;
      b_hs  = m_axil_bvalid && m_axil_bready;
      if (ar_hs) ara = m_axil_araddr;
      if (aw_hs) awa = m_axil_awaddr;
      if (w_hs) begin wd = m_axil_wdata; ws = m_axil_wstrb; end
      @(posedge aclk);
      #1;
      if (areset) begin
        have_aw = 0; have_w = 0; b_pend = 0;
        m_axil_awready = 0; m_axil_wready = 0; m_axil_arready = 0;
        m_axil_bvalid = 0; m_axil_rvalid = 0; m_axil_rdata = 0;
        continue;
      end
      m_axil_awready = sl_rdy;
      m_axil_wready  = sl_rdy;
      m_axil_arready = 1'b1;
      if (r_hs) begin m_axil_rvalid = 0; m_axil_rdata = 0; end
      if (ar_hs) begin
        m_axil_rvalid = 1;
        m_axil_rdata  = mem.exists(ara) ? mem[ara] : 32'h0;
      end
      if (aw_hs) have_aw = 1;
      if (w_hs) have_w = 1;
      if (b_hs) begin m_axil_bvalid = 0; b_pend = 0; end
      if (have_aw && have_w && !b_pend) begin
        cur = mem.exists(awa) ? mem[awa] : 32'h0;
        for (int b = 0; b < 4; b++)
          if (ws[b]) cur[8*b +: 8] = wd[8*b +: 8];
        mem[awa] = cur;
        b_pend = 1; bcnt = bdelay; have_aw = 0; have_w = 0;
      end
      if (b_pend && !m_axil_bvalid) begin
        if (bcnt == 0) m_axil_bvalid = 1;
        else bcnt--;
      end
    end
  end

  task automatic drive_ar(input int m, input logic v,
                          input logic [31:0] a);
    if (m == 0) begin s0_axil_arvalid = v; s0_axil_araddr = a; end
    else begin s1_axil_arvalid = v; s1_axil_araddr = a; end
  endtask

  task automatic drive_aw(input int m, input logic v,
                          input logic [31:0] a);
    if (m == 0) begin s0_axil_awvalid = v; s0_axil_awaddr = a; end
    else begin s1_axil_awvalid = v; s1_axil_awaddr = a; end
  endtask

  task automatic drive_w(input int m, input logic v,
                         input logic [31:0] d, input logic [3:0] s);
    if (m == 0) begin
      s0_axil_wvalid = v; s0_axil_wdata = d; s0_axil_wstrb = s;
    end else begin
      s1_axil_wvalid = v; s1_axil_wdata = d; s1_axil_wstrb = s;
    end
  endtask

  function automatic logic arrdy(input int m);
    return (m == 0) ? s0_axil_arready : s1_axil_arready;
  endfunction

  function automatic logic awrdy(input int m);
    return (m == 0) ? s0_axil_awready : s1_axil_awready;
  endfunction

  function automatic logic wrdy(input int m);
    return (m == 0) ? s0_axil_wready : s1_axil_wready;
  endfunction

  task automatic rd(input int m, input logic [31:0] a);
    int n = 0;
    @(posedge aclk); #1;
    drive_ar(m, 1'b1, a);
    do begin @(negedge aclk); n++; end
    while (!arrdy(m) && n < TMO);
    if (!arrdy(m)) tmo("ar");
    @(posedge aclk); #1;
    drive_ar(m, 1'b0, 32'h0);
  endtask

  task automatic do_aw(input int m, input logic [31:0] a);
    int n = 0;
    @(posedge aclk); #1;
    drive_aw(m, 1'b1, a);
    do begin @(negedge aclk); n++; end
    while (!awrdy(m) && n < TMO);
    if (!awrdy(m)) tmo("aw");
    @(posedge aclk); #1;
    drive_aw(m, 1'b0, 32'h0);
  endtask

  task automatic do_w(input int m, input logic [31:0] d,
                      input logic [3:0] s);
    int n = 0;
    @(posedge aclk); #1;
    drive_w(m, 1'b1, d, s);
    do begin @(negedge aclk); n++; end
    while (!wrdy(m) && n < TMO);
    if (!wrdy(m)) tmo("w");
    @(posedge aclk); #1;
    drive_w(m, 1'b0, 32'h0, 4'h0);
  endtask

  task automatic wr(input int m, input logic [31:0] a,
                    input logic [31:0] d, input logic [3:0] s,
                    input int w_lead);
    fork
      begin
        repeat (w_lead) @(posedge aclk);
        do_aw(m, a);
      end
      do_w(m, d, s);
    join
  endtask

  task automatic expect_rd(input int m, input logic [31:0] a,
                           input logic [31:0] d);
    exp_mar.push_back(a);
    if (m == 0) exp_r0.push_back(d);
    else exp_r1.push_back(d);
  endtask

  task automatic expect_wr(input int m, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] s);
    exp_maw.push_back(a);
    exp_mw.push_back({s, d});
    if (m == 0) exp_b0++;
    else exp_b1++;
  endtask

  task automatic drain();
    int n = 0;
    while (pending() != 0 && n < TMO) begin
      @(posedge aclk);
      n++;
    end
    if (pending() != 0) begin
      tmo("drain");
      exp_mar.delete(); exp_maw.delete(); exp_mw.delete();
      exp_r0.delete(); exp_r1.delete(); exp_b0 = 0; exp_b1 = 0;
    end
    @(posedge aclk); #1;
  endtask

  task automatic blk_check();
    int  n = 0;
    logic done;
    repeat (3) @(negedge aclk);
    do begin
      check("s0_awready_blocked", s0_axil_awready, 0);
      done = s1_axil_bvalid;
      n++;
      if (!done) @(negedge aclk);
    end while (!done && n < TMO);
    if (!done) tmo("s1_bvalid");
  endtask

  initial begin
    int t0, n;
    areset = 1'b1;
    s0_axil_awaddr = 0; s0_axil_awprot = 0; s0_axil_awvalid = 0;
    s0_axil_wdata = 0; s0_axil_wstrb = 0; s0_axil_wvalid = 0;
    s0_axil_araddr = 0; s0_axil_arprot = 0; s0_axil_arvalid = 0;
    s1_axil_awaddr = 0; s1_axil_awprot = 0; s1_axil_awvalid = 0;
    s1_axil_wdata = 0; s1_axil_wstrb = 0; s1_axil_wvalid = 0;
    s1_axil_araddr = 0; s1_axil_arprot = 0; s1_axil_arvalid = 0;
    s0_axil_bready = 1; s0_axil_rready = 1;
    s1_axil_bready = 1; s1_axil_rready = 1;
    mem[32'h10] = 32'hDEADBEEF;

    repeat (3) @(posedge aclk);
    #1 check("reset_outs", any_out(), 0);
    @(negedge aclk);
    areset = 1'b0;
    #1 check("idle_outs", any_out(), 0);

    expect_rd(0, 32'h10, 32'hDEADBEEF);
    rd(0, 32'h10);
    drain();

    expect_wr(1, 32'h20, 32'hA5A5A5A5, 4'h3);
    wr(1, 32'h20, 32'hA5A5A5A5, 4'h3, 2);
    drain();

    expect_rd(1, 32'h20, 32'h0000A5A5);
    rd(1, 32'h20);
    drain();

    for (int k = 0; k < 2; k++) begin
      expect_rd(0, 32'h10, 32'hDEADBEEF);
      expect_rd(1, 32'h20, 32'h0000A5A5);
      fork
        rd(0, 32'h10);
        rd(1, 32'h20);
      join
      drain();
    end

    expect_rd(0, 32'h10, 32'hDEADBEEF);
    rd(0, 32'h10);
    drain();
`ifdef AXIL_ARB_FIXED_PRIO_EN
    expect_rd(0, 32'h10, 32'hDEADBEEF);
    expect_rd(1, 32'h20, 32'h0000A5A5);
`else
    expect_rd(1, 32'h20, 32'h0000A5A5);
    expect_rd(0, 32'h10, 32'hDEADBEEF);
`endif
    fork
      rd(0, 32'h10);
      rd(1, 32'h20);
    join
    drain();

    expect_rd(0, 32'h20, 32'h0000A5A5);
    expect_wr(1, 32'h24, 32'h12345678, 4'hF);
    t0 = cyc;
    fork
      rd(0, 32'h20);
      wr(1, 32'h24, 32'h12345678, 4'hF, 0);
    join
    drain();
    check("concurrent_fast", (cyc - t0) <= 6, 1);

    bdelay = 5;
    expect_wr(1, 32'h28, 32'hCAFEF00D, 4'hF);
    expect_wr(0, 32'h2C, 32'h0BADF00D, 4'hF);
    fork
      wr(1, 32'h28, 32'hCAFEF00D, 4'hF, 0);
      begin
        repeat (2) @(posedge aclk);
        wr(0, 32'h2C, 32'h0BADF00D, 4'hF, 0);
      end
      blk_check();
    join
    drain();
    bdelay = 0;

    expect_rd(1, 32'h24, 32'h12345678);
    rd(1, 32'h24);
    drain();

    sl_rdy = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    drive_aw(0, 1'b1, 32'h30);
    drive_w(0, 1'b1, 32'h11111111, 4'hF);
    n = 0;
    do begin @(negedge aclk); n++; end
    while (!m_axil_awvalid && n < TMO);
    if (!m_axil_awvalid) tmo("fwd");
    check("fwd_awaddr", m_axil_awaddr, 32'h30);
    areset = 1'b1;
    #1 check("rst_fwd_outs", any_out(), 0);
    drive_aw(0, 1'b0, 32'h0);
    drive_w(0, 1'b0, 32'h0, 4'h0);
    sl_rdy = 1'b1;
    repeat (2) @(negedge aclk);
    areset = 1'b0;

    expect_wr(0, 32'h30, 32'h11111111, 4'hF);
    wr(0, 32'h30, 32'h11111111, 4'hF, 0);
    drain();
    expect_rd(0, 32'h30, 32'h11111111);
    rd(0, 32'h30);
    drain();
    check("queues_empty", pending(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
